// File: rtl/dataint_crc_pkg.sv
// dataint_crc_pkg
// Shared definitions for the streaming CRC block:
//   crc_state_t   - frame FSM state encoding (IDLE, ACCUM, DONE)
//   reverse_byte  - bit-reverse an 8-bit data byte (input reflection)
//   reflect_crc   - bit-reverse the low w bits of a 64-bit value (output
//                   reflection for any CRC width up to 64)
package dataint_crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } crc_state_t;

    function automatic logic [7:0] reverse_byte(input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            r[3'(i)] = b[3'(7 - i)];
        end
        return r;
    endfunction

    // Bits at or above w are returned as zero.
    function automatic logic [63:0] reflect_crc(input logic [63:0] v,
                                                input int unsigned w);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < w) begin
                r[6'(i)] = v[6'(w - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dataint_crc_xor_shift_cascade.sv
// dataint_crc_xor_shift_cascade
// Combinational one-byte CRC update: the byte is XORed into the top of the
// register, then eight MSB-first shift/XOR steps with the polynomial follow.
// Ports:
//   i_poly         - generator polynomial, normal form, top bit implicit
//   i_block_input  - current CRC register
//   i_data         - data byte (already conditioned for reflection)
//   o_block_output - CRC register after absorbing the byte
module dataint_crc_xor_shift_cascade #(
    parameter int CRC_WIDTH = 32
) (
    input  logic [CRC_WIDTH-1:0] i_poly,
    input  logic [CRC_WIDTH-1:0] i_block_input,
    input  logic [7:0]           i_data,
    output logic [CRC_WIDTH-1:0] o_block_output
);

    logic [CRC_WIDTH-1:0] data_aligned;
    logic [CRC_WIDTH-1:0] c;

    always_comb begin
        data_aligned = '0;
        data_aligned[CRC_WIDTH-1 -: 8] = i_data;
        c = i_block_input ^ data_aligned;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[CRC_WIDTH-1]) begin
                c = (c << 1) ^ i_poly;
            end else begin
                c = c << 1;
            end
        end
        o_block_output = c;
    end

endmodule

// File: rtl/dataint_crc_stream.sv
// dataint_crc_stream
// Byte-streaming CRC engine with a valid/ready byte input and a valid/ready
// CRC result output. One byte is absorbed per cycle; the final CRC appears one
// cycle after the byte flagged i_last and is held until i_crc_ready.
// Ports:
//   i_clk, i_rst     - clock, asynchronous active-high reset
//   i_clear          - synchronous abort back to IDLE (highest priority)
//   i_valid, o_ready - byte handshake; i_data byte, i_last marks final byte
//   o_crc_valid      - final CRC available (state DONE)
//   i_crc_ready      - consumer takes the final CRC
//   o_crc            - registered final CRC (reflected/XORed as configured)
//   o_byte_count     - bytes accepted in the frame, saturating at 16'hFFFF
//   o_busy           - frame in progress (state ACCUM)
module dataint_crc_stream
    import dataint_crc_pkg::*;
#(
    parameter int                   CRC_WIDTH = 32,
    parameter logic [CRC_WIDTH-1:0] POLY      = 32'h04C11DB7,
    parameter logic [CRC_WIDTH-1:0] INIT      = 32'hFFFFFFFF,
    parameter bit                   REFIN     = 1'b1,
    parameter bit                   REFOUT    = 1'b1,
    parameter logic [CRC_WIDTH-1:0] XOROUT    = 32'hFFFFFFFF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [7:0]           i_data,
    input  logic                 i_last,
    output logic                 o_crc_valid,
    input  logic                 i_crc_ready,
    output logic [CRC_WIDTH-1:0] o_crc,
    output logic [15:0]          o_byte_count,
    output logic                 o_busy
);

    crc_state_t           state, state_nxt;
    logic [CRC_WIDTH-1:0] crc_reg, crc_reg_nxt;
    logic [15:0]          byte_cnt, byte_cnt_nxt;
    logic [CRC_WIDTH-1:0] crc_out_nxt;

    logic [7:0]           data_cond;
    logic [CRC_WIDTH-1:0] crc_upd;
    logic [CRC_WIDTH-1:0] crc_final;
    logic                 accept;

    assign data_cond = REFIN ? reverse_byte(i_data) : i_data;

    dataint_crc_xor_shift_cascade #(
        .CRC_WIDTH (CRC_WIDTH)
    ) u_cascade (
        .i_poly         (POLY),
        .i_block_input  (crc_reg),
        .i_data         (data_cond),
        .o_block_output (crc_upd)
    );

    // Final value is formed from the updated register so o_crc can be loaded
    // on the same edge that accepts the last byte.
    always_comb begin
        if (REFOUT) begin
            crc_final = CRC_WIDTH'(reflect_crc(64'(crc_upd), CRC_WIDTH)) ^ XOROUT;
        end else begin
            crc_final = crc_upd ^ XOROUT;
        end
    end

    assign o_ready      = (state != ST_DONE);
    assign accept       = i_valid && o_ready;
    assign o_crc_valid  = (state == ST_DONE);
    assign o_busy       = (state == ST_ACCUM);
    assign o_byte_count = byte_cnt;

    always_comb begin
        state_nxt    = state;
        crc_reg_nxt  = crc_reg;
        byte_cnt_nxt = byte_cnt;
        crc_out_nxt  = o_crc;

        if (i_clear) begin
            state_nxt    = ST_IDLE;
            crc_reg_nxt  = INIT;
            byte_cnt_nxt = '0;
        end else begin
            case (state)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        crc_reg_nxt  = crc_upd;
                        byte_cnt_nxt = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
                        if (i_last) begin
                            state_nxt   = ST_DONE;
                            crc_out_nxt = crc_final;
                        end else begin
                            state_nxt = ST_ACCUM;
                        end
                    end
                end
                ST_DONE: begin
                    if (i_crc_ready) begin
                        state_nxt    = ST_IDLE;
                        crc_reg_nxt  = INIT;
                        byte_cnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt    = ST_IDLE;
                    crc_reg_nxt  = INIT;
                    byte_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            crc_reg  <= INIT;
            byte_cnt <= '0;
            o_crc    <= '0;
        end else begin
            state    <= state_nxt;
            crc_reg  <= crc_reg_nxt;
            byte_cnt <= byte_cnt_nxt;
            o_crc    <= crc_out_nxt;
        end
    end

endmodule

// File: tb/tb_dataint_crc_stream.sv
// tb_dataint_crc_stream
// Directed bench for dataint_crc_stream: three instances (CRC-32 defaults,
// CRC-16/CCITT-FALSE, CRC-8) share one input stream; outputs are checked
// on the falling clock edge against hand-computed values and, for the long
// zero frame, a reflected LSB-first CRC-32 model.
module tb_dataint_crc_stream;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        valid;
    logic [7:0]  data;
    logic        last;
    logic        crc_ready;

    logic        ready32, crc_valid32, busy32;
    logic [31:0] crc32;
    logic [15:0] cnt32;
    logic        ready16, crc_valid16, busy16;
    logic [15:0] crc16;
    logic [15:0] cnt16;
    logic        ready8, crc_valid8, busy8;
    logic [7:0]  crc8;
    logic [15:0] cnt8;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] msg [0:8];

    dataint_crc_stream dut32 (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_valid(valid),
        .o_ready(ready32), .i_data(data), .i_last(last),
        .o_crc_valid(crc_valid32), .i_crc_ready(crc_ready), .o_crc(crc32),
        .o_byte_count(cnt32), .o_busy(busy32)
    );

    dataint_crc_stream #(
        .CRC_WIDTH(16), .POLY(16'h1021), .INIT(16'hFFFF),
        .REFIN(1'b0), .REFOUT(1'b0), .XOROUT(16'h0000)
    ) dut16 (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_valid(valid),
        .o_ready(ready16), .i_data(data), .i_last(last),
        .o_crc_valid(crc_valid16), .i_crc_ready(crc_ready), .o_crc(crc16),
        .o_byte_count(cnt16), .o_busy(busy16)
    );

    dataint_crc_stream #(
        .CRC_WIDTH(8), .POLY(8'h07), .INIT(8'h00),
        .REFIN(1'b0), .REFOUT(1'b0), .XOROUT(8'h00)
    ) dut8 (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_valid(valid),
        .o_ready(ready8), .i_data(data), .i_last(last),
        .o_crc_valid(crc_valid8), .i_crc_ready(crc_ready), .o_crc(crc8),
        .o_byte_count(cnt8), .o_busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte for one cycle; returns on the following falling edge.
    task automatic send(input logic [7:0] d, input logic l);
        valid = 1'b1;
        data  = d;
        last  = l;
        @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
    endtask

    // Release the result and confirm the return to IDLE.
    task automatic take_result();
        crc_ready = 1'b1;
        @(negedge clk);
        crc_ready = 1'b0;
        check("release_valid", {63'd0, crc_valid32}, 64'd0);
        check("release_count", {48'd0, cnt32}, 64'd0);
        check("release_ready", {63'd0, ready32}, 64'd1);
    endtask

    // Reflected (LSB-first, 0xEDB88320) CRC-32 of n zero bytes.
    function automatic logic [31:0] crc32_zeros(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    initial begin
        logic [31:0] exp_zero;

        for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
        rst = 1'b1; clear = 1'b0; valid = 1'b0; data = '0; last = 1'b0; crc_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_crc",   {32'd0, crc32}, 64'd0);
        check("rst_valid", {63'd0, crc_valid32}, 64'd0);
        check("rst_count", {48'd0, cnt32}, 64'd0);
        check("rst_busy",  {63'd0, busy32}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {63'd0, ready32}, 64'd1);

        // "123456789" back to back on all three widths
        for (int i = 0; i < 8; i++) send(msg[i], 1'b0);
        check("a_busy_mid",   {63'd0, busy32}, 64'd1);
        check("a_valid_pre",  {63'd0, crc_valid32}, 64'd0);
        check("a_count_mid",  {48'd0, cnt32}, 64'd8);
        send(msg[8], 1'b1);
        check("a_valid32", {63'd0, crc_valid32}, 64'd1);
        check("a_crc32",   {32'd0, crc32}, 64'hCBF43926);
        check("a_count32", {48'd0, cnt32}, 64'd9);
        check("a_ready32", {63'd0, ready32}, 64'd0);
        check("a_busy32",  {63'd0, busy32}, 64'd0);
        check("a_crc16",   {48'd0, crc16}, 64'h29B1);
        check("a_crc8",    {56'd0, crc8}, 64'hF4);
        check("a_valid8",  {63'd0, crc_valid8}, 64'd1);
        take_result();

        // Single zero byte with i_last straight from IDLE
        send(8'h00, 1'b1);
        check("b_valid", {63'd0, crc_valid32}, 64'd1);
        check("b_crc",   {32'd0, crc32}, 64'hD202EF8D);
        check("b_count", {48'd0, cnt32}, 64'd1);
        check("b_busy",  {63'd0, busy32}, 64'd0);
        take_result();

        // Random i_valid gaps, then hold result with i_crc_ready low
        for (int i = 0; i < 9; i++) begin
            send(msg[i], (i == 8) ? 1'b1 : 1'b0);
            if (i < 8) begin
                for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                    check("c_gap_count", {48'd0, cnt32}, 64'(i + 1));
                    check("c_gap_busy",  {63'd0, busy32}, 64'd1);
                    @(negedge clk);
                end
            end
        end
        for (int h = 0; h < 5; h++) begin
            check("c_hold_crc",   {32'd0, crc32}, 64'hCBF43926);
            check("c_hold_valid", {63'd0, crc_valid32}, 64'd1);
            check("c_hold_ready", {63'd0, ready32}, 64'd0);
            check("c_hold_count", {48'd0, cnt32}, 64'd9);
            valid = 1'b1; data = 8'hAA; // must be ignored while in DONE
            @(negedge clk);
            valid = 1'b0;
        end
        check("c_after_crc", {32'd0, crc32}, 64'hCBF43926);
        take_result();

        // Partial frame aborted by i_clear with a byte presented
        for (int i = 0; i < 4; i++) send(msg[i], 1'b0);
        clear = 1'b1; valid = 1'b1; data = 8'h35; last = 1'b0;
        @(negedge clk);
        clear = 1'b0; valid = 1'b0;
        check("d_clr_count", {48'd0, cnt32}, 64'd0);
        check("d_clr_busy",  {63'd0, busy32}, 64'd0);
        for (int i = 0; i < 9; i++) send(msg[i], (i == 8) ? 1'b1 : 1'b0);
        check("d_crc",   {32'd0, crc32}, 64'hCBF43926);
        check("d_count", {48'd0, cnt32}, 64'd9);
        take_result();

        // Partial frame discarded by an asynchronous reset pulse
        for (int i = 0; i < 4; i++) send(msg[i], 1'b0);
        #2 rst = 1'b1;
        #1;
        check("e_rst_count", {48'd0, cnt32}, 64'd0);
        check("e_rst_busy",  {63'd0, busy32}, 64'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 9; i++) send(msg[i], (i == 8) ? 1'b1 : 1'b0);
        check("e_crc",   {32'd0, crc32}, 64'hCBF43926);
        check("e_count", {48'd0, cnt32}, 64'd9);
        take_result();

        // 70000 zero bytes: counter saturates, CRC against model
        exp_zero = crc32_zeros(70000);
        for (int i = 0; i < 69999; i++) send(8'h00, 1'b0);
        send(8'h00, 1'b1);
        check("f_valid", {63'd0, crc_valid32}, 64'd1);
        check("f_count", {48'd0, cnt32}, 64'hFFFF);
        check("f_crc",   {32'd0, crc32}, {32'd0, exp_zero});
        take_result();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
